// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin lock arbiter.
package arb_pkg;

  localparam int NUM_OF_CORES_DEF = 4;
  localparam int CORE_ID_W        = $clog2(NUM_OF_CORES_DEF);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  typedef logic [NUM_OF_CORES_DEF-1:0] core_vec_t;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority pick: first set request at or after ptr, modulo N.
module rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] pick,
  output logic                 any_valid
);

  localparam int W = $clog2(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W-1:0]   offset;

  // Doubling the vector turns the rotate into a plain shift; bit 0 of rotated is core ptr.
  always_comb begin
    doubled = {req, req};
    rotated = N'(doubled >> ptr);
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = W'(i);
    end
    pick      = ptr + offset;
    any_valid = |req;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Work-conserving round-robin arbiter that locks onto a core until its last beat.
// Define ARB_TIMEOUT_EN to force-release locks held for MAX_HOLD_CYCLES cycles.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_OF_CORES    = NUM_OF_CORES_DEF,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_OF_CORES-1:0]         req,
  input  logic [NUM_OF_CORES-1:0]         req_last,
  input  logic                            bus_ready,
  output logic [NUM_OF_CORES-1:0]         grant,
  output logic [$clog2(NUM_OF_CORES)-1:0] grant_id,
  output logic                            bus_valid,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int ID_W = $clog2(NUM_OF_CORES);
  localparam logic [NUM_OF_CORES-1:0] ONE = NUM_OF_CORES'(1);

  arb_state_t              state_q, state_d;
  logic [NUM_OF_CORES-1:0] grant_q, grant_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [ID_W-1:0] sel_ptr;
  logic [ID_W-1:0] pick;
  logic            any_valid;
  logic            fire;
  logic            last_fire;
  logic            timeout_hit;
  logic            release_lock;

  assign fire         = busy_q && req[grant_id_q] && bus_ready;
  assign last_fire    = fire && req_last[grant_id_q];
  assign release_lock = last_fire || timeout_hit;

  // On release the releasing core lands last in the scan, so it only wins when alone.
  assign sel_ptr = release_lock ? grant_id_q + ID_W'(1) : ptr_q;

  rr_select #(
    .N(NUM_OF_CORES)
  ) u_select (
    .req      (req),
    .ptr      (sel_ptr),
    .pick     (pick),
    .any_valid(any_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES) + 1;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign timeout_hit = busy_q && !last_fire &&
                       (hold_cnt_q == HOLD_W'(MAX_HOLD_CYCLES - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    if (!busy_q || release_lock) hold_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^MAX_HOLD_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    ptr_d         = ptr_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = LOCKED;
          grant_d    = ONE << pick;
          grant_id_d = pick;
          busy_d     = 1'b1;
        end
      end
      LOCKED: begin
        if (release_lock) begin
          ptr_d         = sel_ptr;
          timeout_err_d = timeout_hit;
          if (any_valid) begin
            grant_d    = ONE << pick;
            grant_id_d = pick;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      ptr_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      ptr_q         <= ptr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign bus_valid   = busy_q && req[grant_id_q];

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed scoreboard bench for rr_lock_arbiter (4 cores, hold limit 8).
module tb_rr_lock_arbiter;
  import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       terr;
    string      tag;
  } exp_t;

  logic      clk = 1'b0;
  logic      reset;
  core_vec_t req;
  core_vec_t req_last;
  logic      bus_ready;
  core_vec_t grant;
  logic [1:0] grant_id;
  logic      bus_valid;
  logic      busy;
  logic      timeout_err;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] prev_grant;
  logic       prev_busy;

  rr_lock_arbiter #(
    .NUM_OF_CORES   (4),
    .MAX_HOLD_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_last   (req_last),
    .bus_ready  (bus_ready),
    .grant      (grant),
    .grant_id   (grant_id),
    .bus_valid  (bus_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] onehot_to_id(input logic [3:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
    return id;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "/grant"}, grant, e.grant);
      check({e.tag, "/grant_id"}, {2'b00, grant_id}, {2'b00, e.id});
      check({e.tag, "/busy"}, {3'b000, busy}, {3'b000, e.busy});
      check({e.tag, "/timeout_err"}, {3'b000, timeout_err}, {3'b000, e.terr});
    end
  endtask

  // Drive one cycle, check bus_valid from the previous state, push and pop the post-edge result.
  task automatic apply_stimulus(input string tag, input logic rst, input logic [3:0] r,
                                input logic [3:0] l, input logic rdy,
                                input logic [3:0] exp_grant, input logic exp_terr);
    exp_t e;
    reset     = rst;
    req       = r;
    req_last  = l;
    bus_ready = rdy;
    #1;
    check({tag, "/bus_valid"}, {3'b000, bus_valid}, {3'b000, prev_busy && |(r & prev_grant)});
    e.grant = exp_grant;
    e.id    = onehot_to_id(exp_grant);
    e.busy  = |exp_grant;
    e.terr  = exp_terr;
    e.tag   = tag;
    sb.push_back(e);
    prev_grant = exp_grant;
    prev_busy  = |exp_grant;
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; req_last = '0; bus_ready = 1'b0;
    @(posedge clk); #1;
    prev_grant = 4'b0000;
    prev_busy  = 1'b0;

    apply_stimulus("rst",        1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus("s1_grant",   1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0);
    apply_stimulus("s1_b2b",     1'b0, 4'b1010, 4'b0010, 1'b1, 4'b1000, 1'b0);
    apply_stimulus("solo_a",     1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0);
    apply_stimulus("solo_b",     1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0);
    apply_stimulus("ptr_wrap",   1'b0, 4'b1001, 4'b1000, 1'b1, 4'b0001, 1'b0);

    apply_stimulus("rst2",       1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus("c2_grant",   1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0);
    apply_stimulus("c2_beat1",   1'b0, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b0);
    apply_stimulus("c2_wait",    1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0);
    apply_stimulus("c2_beat2",   1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0);
    apply_stimulus("c2_last",    1'b0, 4'b0101, 4'b0100, 1'b1, 4'b0001, 1'b0);
    apply_stimulus("rr_1",       1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);
    apply_stimulus("rr_2",       1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    apply_stimulus("rr_3",       1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    apply_stimulus("rr_0",       1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    apply_stimulus("rr_1b",      1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);

    apply_stimulus("rst3",       1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus("c1_grant",   1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0);
    apply_stimulus("c1_beat1",   1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0);
    apply_stimulus("mid_reset",  1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0);
    apply_stimulus("post_reset", 1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
    apply_stimulus("stall_a",    1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0001, 1'b0);
    apply_stimulus("stall_b",    1'b0, 4'b0010, 4'b0001, 1'b1, 4'b0001, 1'b0);

    apply_stimulus("rst4",       1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus("to_grant",   1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0);
    for (int k = 2; k <= 10; k++) begin
      apply_stimulus($sformatf("to_cyc%0d", k), 1'b0, 4'b0011, 4'b0000, 1'b1,
                     (TO_EN && k >= 9) ? 4'b0010 : 4'b0001, TO_EN && (k == 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
